// File: rtl/mem_bus_bridge.sv
// Bridges the CPU level-held read/write request onto one Wishbone classic transaction.
// Optional ack_i watchdog: define MEM_BUS_TIMEOUT_EN.
module mem_bus_bridge #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0] ERR_DATA       = 32'hBAD0_BAD0
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                read,
  input  logic                write,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] sel,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                bus_error,
  output logic                cyc_o,
  output logic                stb_o,
  output logic                we_o,
  output logic [ADDR_W-1:0]   adr_o,
  output logic [DATA_W-1:0]   dat_o,
  output logic [DATA_W/8-1:0] sel_o,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic                ack_i
);

  localparam int SEL_W = DATA_W / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [DATA_W-1:0] dat_q, dat_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_cfg_s;
  assign unused_cfg_s = (^ERR_DATA) ^ (TIMEOUT_CYCLES > 0);
`endif

  // Next-state and next-output computation for the IDLE/BUS/DONE sequencer
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
`ifdef MEM_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (write || read) begin
          adr_d   = address;
          dat_d   = wdata;
          sel_d   = sel;
          we_d    = write;
          cyc_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = ST_BUS;
`ifdef MEM_BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          cyc_d  = 1'b0;
          busy_d = 1'b0;
        end
      end
      ST_BUS: begin
        if (ack_i) begin
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = dat_i;
          end else begin
            rdata_d = rdata_q;
          end
`ifdef MEM_BUS_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          // ack_i is checked first, so a same-edge ack completes normally
          cyc_d   = 1'b0;
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          err_d   = 1'b1;
          state_d = ST_DONE;
          if (!we_q) begin
            rdata_d = ERR_DATA;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`else
        end else begin
          cyc_d = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        // The request unit still holds its old request here, so it is ignored
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
`ifdef MEM_BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;
  assign we_o  = we_q;
  assign adr_o = adr_q;
  assign dat_o = dat_q;
  assign sel_o = sel_q;
  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
`ifdef MEM_BUS_TIMEOUT_EN
  assign bus_error = err_q;
`else
  assign bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Randomized self-checking bench for mem_bus_bridge with a transaction-level reference model.
module tb_mem_bus_bridge;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 255;
`endif

  logic        clk;
  logic        n_rst;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;
  logic        bus_error;
  logic        cyc_o;
  logic        stb_o;
  logic        we_o;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic [31:0] dat_i;
  logic        ack_i;

  int          total;
  int          bad;
  logic [31:0] exp_rdata;

  mem_bus_bridge #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TO_CYC),
    .ERR_DATA       (32'hBAD0_BAD0)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .read      (read),
    .write     (write),
    .address   (address),
    .wdata     (wdata),
    .sel       (sel),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .bus_error (bus_error),
    .cyc_o     (cyc_o),
    .stb_o     (stb_o),
    .we_o      (we_o),
    .adr_o     (adr_o),
    .dat_o     (dat_o),
    .sel_o     (sel_o),
    .dat_i     (dat_i),
    .ack_i     (ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full request: accept, optional wait states with CPU-side churn, ack, DONE
  task automatic do_txn(input logic wr, input logic rd, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] sl, input int waits,
                        input logic [31:0] slave_data);
    write = wr; read = rd; address = addr; wdata = wd; sel = sl; ack_i = 1'b0;
    @(posedge clk); #1;
    check_val("cyc_start", 32'(cyc_o), 32'd1);
    check_val("stb_start", 32'(stb_o), 32'd1);
    check_val("busy_start", 32'(busy), 32'd1);
    check_val("we_start", 32'(we_o), 32'(wr));
    check_val("adr_start", adr_o, addr);
    check_val("dat_start", dat_o, wd);
    check_val("sel_start", 32'(sel_o), 32'(sl));
    check_val("ack_early", 32'(ack), 32'd0);
    for (int i = 0; i < waits; i++) begin
      address = $urandom; wdata = $urandom; sel = 4'($urandom);
      @(posedge clk); #1;
      check_val("cyc_hold", 32'(cyc_o), 32'd1);
      check_val("adr_hold", adr_o, addr);
      check_val("dat_hold", dat_o, wd);
      check_val("sel_hold", 32'(sel_o), 32'(sl));
      check_val("we_hold", 32'(we_o), 32'(wr));
      check_val("ack_wait", 32'(ack), 32'd0);
      check_val("err_wait", 32'(bus_error), 32'd0);
    end
    ack_i = 1'b1; dat_i = slave_data;
    @(posedge clk); #1;
    ack_i = 1'b0; dat_i = $urandom;
    if (!wr) exp_rdata = slave_data;
    check_val("ack_pulse", 32'(ack), 32'd1);
    check_val("busy_done", 32'(busy), 32'd0);
    check_val("cyc_done", 32'(cyc_o), 32'd0);
    check_val("stb_done", 32'(stb_o), 32'd0);
    check_val("rdata", rdata, exp_rdata);
    check_val("err_normal", 32'(bus_error), 32'd0);
    address = $urandom;
    ack_i = 1'b1;
    @(posedge clk); #1;
    ack_i = 1'b0;
    check_val("ack_once", 32'(ack), 32'd0);
    check_val("cyc_after_done", 32'(cyc_o), 32'd0);
    check_val("busy_after_done", 32'(busy), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    read = 1'b0; write = 1'b0;
    for (int i = 0; i < n; i++) begin
      ack_i = 1'($urandom);
      @(posedge clk); #1;
      check_val("idle_cyc", 32'(cyc_o), 32'd0);
      check_val("idle_ack", 32'(ack), 32'd0);
    end
    ack_i = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0; exp_rdata = 32'h0;
    n_rst = 1'b0; read = 1'b0; write = 1'b0; address = 32'h0; wdata = 32'h0;
    sel = 4'h0; dat_i = 32'h0; ack_i = 1'b0;
    #12;
    check_val("rst_cyc", 32'(cyc_o), 32'd0);
    check_val("rst_stb", 32'(stb_o), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ack", 32'(ack), 32'd0);
    check_val("rst_we", 32'(we_o), 32'd0);
    check_val("rst_adr", adr_o, 32'h0);
    check_val("rst_dat", dat_o, 32'h0);
    check_val("rst_sel", 32'(sel_o), 32'd0);
    check_val("rst_rdata", rdata, 32'h0);
    check_val("rst_err", 32'(bus_error), 32'd0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    do_txn(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'hF, 0, 32'h1234_5678);
    idle_cycles(1);
    do_txn(1'b1, 1'b0, 32'h0000_2000, 32'hCAFE_F00D, 4'b0011, 3, 32'hDEAD_BEEF);
    idle_cycles(1);
    do_txn(1'b0, 1'b1, 32'h0000_0100, 32'h0, 4'hF, 1, 32'h1111_2222);
    do_txn(1'b0, 1'b1, 32'h0000_0104, 32'h0, 4'hF, 0, 32'h3333_4444);
    do_txn(1'b1, 1'b1, 32'h0000_0200, 32'h5555_6666, 4'hC, 2, 32'h7777_8888);
    idle_cycles(2);

    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = int'($urandom_range(0, 2));
      do_txn(1'(kind != 0), 1'(kind != 1), $urandom, $urandom, 4'($urandom),
             int'($urandom_range(0, 4)), $urandom);
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 2)));
    end

    // Asynchronous reset between edges while a transaction is outstanding
    idle_cycles(1);
    read = 1'b1; write = 1'b0; address = 32'h0000_0300;
    @(posedge clk); #1;
    check_val("pre_rst_cyc", 32'(cyc_o), 32'd1);
    #2 n_rst = 1'b0;
    #1;
    check_val("arst_cyc", 32'(cyc_o), 32'd0);
    check_val("arst_stb", 32'(stb_o), 32'd0);
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_ack", 32'(ack), 32'd0);
    check_val("arst_adr", adr_o, 32'h0);
    check_val("arst_rdata", rdata, 32'h0);
    exp_rdata = 32'h0;
    read = 1'b0;
    @(posedge clk); #2;
    n_rst = 1'b1;
    idle_cycles(3);

`ifdef MEM_BUS_TIMEOUT_EN
    read = 1'b1; write = 1'b0; address = 32'h0000_0400; ack_i = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_val("to_cyc_hold", 32'(cyc_o), 32'd1);
      check_val("to_err_early", 32'(bus_error), 32'd0);
    end
    @(posedge clk); #1;
    exp_rdata = 32'hBAD0_BAD0;
    check_val("to_ack", 32'(ack), 32'd1);
    check_val("to_err", 32'(bus_error), 32'd1);
    check_val("to_cyc", 32'(cyc_o), 32'd0);
    check_val("to_rdata", rdata, exp_rdata);
    @(posedge clk); #1;
    check_val("to_err_once", 32'(bus_error), 32'd0);
    do_txn(1'b0, 1'b1, 32'h0000_0404, 32'h0, 4'hF, 3, 32'h0BAD_F00D);
    idle_cycles(1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
